// File: rtl/pellet_plotter_if.sv
// pellet_plotter_if: the draw-request side and the pixel-write side of
// pellet_plotter, bundled into one interface.
//   slave  modport - used by pellet_plotter (takes the request, drives pixels)
//   master modport - used by the requester / frame-buffer side
// Request:  start, origin_x, origin_y, shape[24:0], fg_colour, bg_colour
// Pixels:   x, y, colour, plot, busy, done
interface pellet_plotter_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) ();
    logic                start;
    logic [X_W-1:0]      origin_x;
    logic [Y_W-1:0]      origin_y;
    logic [24:0]         shape;
    logic [COLOUR_W-1:0] fg_colour;
    logic [COLOUR_W-1:0] bg_colour;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport slave (
        input  start, origin_x, origin_y, shape, fg_colour, bg_colour,
        output x, y, colour, plot, busy, done
    );

    modport master (
        output start, origin_x, origin_y, shape, fg_colour, bg_colour,
        input  x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/pellet_plotter.sv
// pellet_plotter: rasterises one latched 5x5 sprite bitmap into a pixel-write
// port, one pixel per clock in row-major order, with screen-edge clipping.
// Ports:
//   clock - sole clock, rising edge
//   reset - asynchronous, active-high; returns to IDLE with all outputs 0
//   bus   - pellet_plotter_if.slave (request inputs, registered pixel outputs)
// Build option: define PELLET_PLOTTER_TRANSPARENT_EN to leave clear shape
// bits unplotted (bg_colour ignored); otherwise they are drawn in bg_colour.
module pellet_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int X_MAX    = 160,
    parameter int Y_MAX    = 120
) (
    input logic             clock,
    input logic             reset,
    pellet_plotter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t state, state_next;

    // Request captured on start; the shape is shifted left each pixel so
    // the current bit is always shape_q[24].
    logic [24:0]         shape_q, shape_d;
    logic [X_W-1:0]      ox_q, ox_d;
    logic [Y_W-1:0]      oy_q, oy_d;
    logic [COLOUR_W-1:0] fg_q, fg_d;
`ifndef PELLET_PLOTTER_TRANSPARENT_EN
    logic [COLOUR_W-1:0] bg_q, bg_d;
`endif
    logic [2:0]          row_q, row_d;
    logic [2:0]          col_q, col_d;

    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // One extra bit so origin + offset never wraps before the clip compare.
    logic [X_W:0]        x_sum;
    logic [Y_W:0]        y_sum;
    logic                on_screen;

    always_comb begin
        state_next = state;
        shape_d    = shape_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        fg_d       = fg_q;
`ifndef PELLET_PLOTTER_TRANSPARENT_EN
        bg_d       = bg_q;
`endif
        row_d      = row_q;
        col_d      = col_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        x_sum     = {1'b0, ox_q} + (X_W+1)'(col_q);
        y_sum     = {1'b0, oy_q} + (Y_W+1)'(row_q);
        on_screen = (x_sum < (X_W+1)'(X_MAX)) && (y_sum < (Y_W+1)'(Y_MAX));

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = DRAW;
                    shape_d    = bus.shape;
                    ox_d       = bus.origin_x;
                    oy_d       = bus.origin_y;
                    fg_d       = bus.fg_colour;
`ifndef PELLET_PLOTTER_TRANSPARENT_EN
                    bg_d       = bus.bg_colour;
`endif
                    row_d      = '0;
                    col_d      = '0;
                    busy_d     = 1'b1;
                end
            end

            DRAW: begin
                busy_d  = 1'b1;
                x_d     = x_sum[X_W-1:0];
                y_d     = y_sum[Y_W-1:0];
                shape_d = {shape_q[23:0], 1'b0};
`ifdef PELLET_PLOTTER_TRANSPARENT_EN
                colour_d = fg_q;
                plot_d   = on_screen && shape_q[24];
`else
                colour_d = shape_q[24] ? fg_q : bg_q;
                plot_d   = on_screen;
`endif
                if (col_q == 3'd4) begin
                    col_d = '0;
                    row_d = row_q + 3'd1;
                end else begin
                    col_d = col_q + 3'd1;
                end
                if (row_q == 3'd4 && col_q == 3'd4)
                    state_next = DONE;
            end

            DONE: begin
                done_d     = 1'b1;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shape_q  <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            fg_q     <= '0;
`ifndef PELLET_PLOTTER_TRANSPARENT_EN
            bg_q     <= '0;
`endif
            row_q    <= '0;
            col_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            shape_q  <= shape_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            fg_q     <= fg_d;
`ifndef PELLET_PLOTTER_TRANSPARENT_EN
            bg_q     <= bg_d;
`endif
            row_q    <= row_d;
            col_q    <= col_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule
